mem_stage_wait: RTL and testbench
=================================

Name: mem_stage_wait

Overview:
- Parametrised successor to the single-cycle MEM stage. Contains the data memory and the MEM/WB pipeline register.
- Models a memory with a configurable number of wait states. It raises `freeze` to stall the upstream pipeline until the access completes.
- Sits between the EXE/MEM register and the WB stage. Non-memory instructions pass through with one cycle of latency.

Parameters:
- DATA_W, 32: width of data, address and PC.
- DEPTH, 64: number of data-memory words; must be a power of two.
- REG_W, 4: width of the destination register index.
- WAIT_CYCLES, 2: extra cycles per load/store (0 to 15); 0 gives a single-cycle access.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- pc_in  in  DATA_W  PC of the instruction in MEM
- wb_en  in  1  writeback enable
- mem_r_en  in  1  load request
- mem_w_en  in  1  store request
- alu_res  in  DATA_W  byte address, or ALU result
- val_rm  in  DATA_W  store data
- dest  in  REG_W  destination register
- freeze  out  1  stall request to upstream stages (combinational)
- pc_out  out  DATA_W  registered PC
- wb_en_out  out  1  registered writeback enable
- mem_r_en_out  out  1  registered load flag (selects mem_data_out in WB)
- alu_res_out  out  DATA_W  registered ALU result
- mem_data_out  out  DATA_W  registered load data
- dest_out  out  REG_W  registered destination

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs go to 0 and the FSM goes to IDLE with cnt=0.
  - Memory array contents are not reset.
- Memory operation: mem_op = mem_r_en | mem_w_en. If both are set, the store wins and mem_r_en_out is registered as 0.
- Word index is alu_res[log2(DEPTH)+1:2]. Address bits [1:0] are ignored. Higher bits are ignored, so addresses wrap modulo DEPTH words.
- FSM has two states, IDLE and WAIT, plus a wait counter cnt (4 bits):
  - IDLE, mem_op=1, WAIT_CYCLES>0: freeze=1, go to WAIT, cnt<=1.
  - IDLE, mem_op=0, or WAIT_CYCLES=0: freeze=0, stay in IDLE.
  - WAIT, cnt<WAIT_CYCLES: freeze=1, cnt<=cnt+1.
  - WAIT, cnt==WAIT_CYCLES: freeze=0; this is the completion cycle. Go to IDLE and set cnt<=0.
- freeze is combinational from the state, cnt and mem_op.
- Upstream must hold all inputs stable while freeze=1. Inputs are not latched internally.
- Pipeline register:
  - On each clock edge with freeze=0, all *_out outputs load from the inputs.
  - On each edge with freeze=1, the register loads a bubble: wb_en_out=0 and mem_r_en_out=0. The other outputs hold their values.
- Latency:
  - A memory instruction occupies the stage for 1+WAIT_CYCLES cycles.
  - A non-memory instruction occupies it for 1 cycle.
  - Results appear on the outputs the cycle after the completion edge.
- Store: the array is written exactly once, at the completion edge. No write occurs while freeze=1.
- Load: the array is read combinationally and mem_data_out is captured at the completion edge. Non-load instructions load mem_data_out with 0.
- Store followed by a load to the same word: the load returns the newly stored data, because the accesses are in separate cycles.
- Reset during WAIT: the access is aborted, no write occurs, and freeze drops as soon as reset is asserted.
- Back-to-back memory operations: the IDLE to WAIT transition happens again on the cycle immediately after completion, with no idle gap.

Optional Feature:
- Macro: MEM_BYTE_ACCESS_EN.
- When defined:
  - An extra input `byte_en` (1 bit) is added and registered alongside the other inputs.
  - Store with byte_en=1 writes only lane alu_res[1:0] with val_rm[7:0]; the other lanes are preserved.
  - Load with byte_en=1 returns the selected lane, zero-extended to DATA_W.
  - Wait-state timing is unchanged.
- When undefined:
  - No byte_en port.
  - All accesses are full words, and alu_res[1:0] is ignored.

Test Plan:
- Reset: hold rst=0 with random inputs -> all outputs 0, freeze=0; release, then present a non-memory op (wb_en=1, alu_res=0x55, dest=3) -> next cycle wb_en_out=1, alu_res_out=0x55, dest_out=3, freeze never asserted.
- Store then load, WAIT_CYCLES=2:
  - Store 0xDEADBEEF to address 0x10 -> freeze high for exactly 2 cycles, then low, and WB sees bubbles during the stall.
  - Load from 0x10 -> freeze high for 2 cycles; after completion, mem_data_out=0xDEADBEEF and mem_r_en_out=1.
- Wrap-around, DEPTH=64: store 0x1 to address 0x100, then load from 0x0 -> 0x1. Load from 0x103 returns the same word.
- Reset mid-access: issue store 0xAAAA to 0x8 (pre-loaded with 0x1234), assert rst during the second frozen cycle -> freeze=0 immediately; a later load from 0x8 returns 0x1234.
- WAIT_CYCLES=0 build: alternate loads and stores every cycle -> freeze stays 0 and results update every cycle.
- MEM_BYTE_ACCESS_EN: word 0x11223344 at 0x20; store byte 0xFF to 0x21 -> word reads 0x1122FF44; byte load from 0x23 -> 0x00000011.

Source files
------------

// File: rtl/mem_stage_wait.sv
// mem_stage_wait: MEM stage with wait-stated data memory and MEM/WB pipeline register
//
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_pc_in, i_wb_en, i_dest       instruction context from EXE/MEM
//   i_mem_r_en, i_mem_w_en         load / store request (store wins if both set)
//   i_alu_res, i_val_rm            byte address or ALU result, store data
//   o_freeze                       combinational stall request to upstream stages
//   o_*_out                        MEM/WB pipeline register towards WB
// Optional feature macro MEM_BYTE_ACCESS_EN adds i_byte_en / o_byte_en_out for
// single-byte stores and zero-extended byte loads.
module mem_stage_wait #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 64,
    parameter int REG_W       = 4,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_pc_in,
    input  logic              i_wb_en,
    input  logic              i_mem_r_en,
    input  logic              i_mem_w_en,
    input  logic [DATA_W-1:0] i_alu_res,
    input  logic [DATA_W-1:0] i_val_rm,
    input  logic [REG_W-1:0]  i_dest,
`ifdef MEM_BYTE_ACCESS_EN
    input  logic              i_byte_en,
    output logic              o_byte_en_out,
`endif
    output logic              o_freeze,
    output logic [DATA_W-1:0] o_pc_out,
    output logic              o_wb_en_out,
    output logic              o_mem_r_en_out,
    output logic [DATA_W-1:0] o_alu_res_out,
    output logic [DATA_W-1:0] o_mem_data_out,
    output logic [REG_W-1:0]  o_dest_out
);
    localparam int         AW = $clog2(DEPTH);
    localparam logic [3:0] WC = 4'(WAIT_CYCLES);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t            r_state, w_nstate;
    logic [3:0]        r_cnt, w_ncnt;
    logic              w_freeze;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     w_idx;
    logic [DATA_W-1:0] w_rd, w_ld, w_wdata;
    logic              w_mem_op, w_load, w_we;
    logic              w_unused;

    assign w_mem_op = i_mem_r_en | i_mem_w_en;
    assign w_load   = i_mem_r_en & ~i_mem_w_en;
    assign w_idx    = i_alu_res[AW+1:2];
    assign w_rd     = r_mem[w_idx];
    assign w_unused = &{1'b0, i_alu_res};

`ifdef MEM_BYTE_ACCESS_EN
    logic [4:0] w_sh;
    assign w_sh = {i_alu_res[1:0], 3'b000};
    always_comb begin
        w_wdata = i_val_rm;
        if (i_byte_en) begin
            w_wdata = w_rd;
            w_wdata[w_sh +: 8] = i_val_rm[7:0];
        end
    end
    assign w_ld = i_byte_en ? DATA_W'(w_rd[w_sh +: 8]) : w_rd;
`else
    assign w_wdata = i_val_rm;
    assign w_ld    = w_rd;
`endif

    always_comb begin
        w_nstate = r_state;
        w_ncnt   = r_cnt;
        w_freeze = 1'b0;
        if (r_state == S_IDLE) begin
            if (w_mem_op && WC != 4'd0) begin
                w_freeze = 1'b1;
                w_nstate = S_WAIT;
                w_ncnt   = 4'd1;
            end
        end else if (r_cnt != WC) begin
            w_freeze = 1'b1;
            w_ncnt   = r_cnt + 4'd1;
        end else begin
            w_nstate = S_IDLE;
            w_ncnt   = 4'd0;
        end
    end

    // Gating with reset drops the stall immediately when an access is aborted.
    assign o_freeze = w_freeze & i_rst_n;
    assign w_we     = i_mem_w_en & ~o_freeze & i_rst_n;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_nstate;
            r_cnt   <= w_ncnt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_we) r_mem[w_idx] <= w_wdata;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_pc_out       <= '0;
            o_wb_en_out    <= 1'b0;
            o_mem_r_en_out <= 1'b0;
            o_alu_res_out  <= '0;
            o_mem_data_out <= '0;
            o_dest_out     <= '0;
`ifdef MEM_BYTE_ACCESS_EN
            o_byte_en_out  <= 1'b0;
`endif
        end else if (o_freeze) begin
            o_wb_en_out    <= 1'b0;
            o_mem_r_en_out <= 1'b0;
        end else begin
            o_pc_out       <= i_pc_in;
            o_wb_en_out    <= i_wb_en;
            o_mem_r_en_out <= w_load;
            o_alu_res_out  <= i_alu_res;
            o_mem_data_out <= w_load ? w_ld : '0;
            o_dest_out     <= i_dest;
`ifdef MEM_BYTE_ACCESS_EN
            o_byte_en_out  <= i_byte_en;
`endif
        end
    end
endmodule

// File: tb/tb_mem_stage_wait.sv
// tb_mem_stage_wait: directed-vector bench for mem_stage_wait (2 and 0 wait states)
module tb_mem_stage_wait;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] pc = '0, alu = '0, vrm = '0;
    logic        wb = 1'b0, rd = 1'b0, wr = 1'b0, be = 1'b0;
    logic [3:0]  dst = '0;
    logic        frz, wb_o, rd_o;
    logic [31:0] pc_o, alu_o, md_o;
    logic [3:0]  dst_o;
    logic        z_rd = 1'b0, z_wr = 1'b0;
    logic [31:0] z_alu = '0, z_vrm = '0;
    logic        z_frz, z_wb_o, z_rd_o;
    logic [31:0] z_pc_o, z_alu_o, z_md_o;
    logic [3:0]  z_dst_o;
`ifdef MEM_BYTE_ACCESS_EN
    logic        be_o, z_be_o;
`endif
    int n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    mem_stage_wait #(.DATA_W(32), .DEPTH(64), .REG_W(4), .WAIT_CYCLES(2)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_pc_in(pc), .i_wb_en(wb),
        .i_mem_r_en(rd), .i_mem_w_en(wr), .i_alu_res(alu), .i_val_rm(vrm), .i_dest(dst),
`ifdef MEM_BYTE_ACCESS_EN
        .i_byte_en(be), .o_byte_en_out(be_o),
`endif
        .o_freeze(frz), .o_pc_out(pc_o), .o_wb_en_out(wb_o), .o_mem_r_en_out(rd_o),
        .o_alu_res_out(alu_o), .o_mem_data_out(md_o), .o_dest_out(dst_o)
    );

    mem_stage_wait #(.DATA_W(32), .DEPTH(64), .REG_W(4), .WAIT_CYCLES(0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_pc_in(pc), .i_wb_en(wb),
        .i_mem_r_en(z_rd), .i_mem_w_en(z_wr), .i_alu_res(z_alu), .i_val_rm(z_vrm), .i_dest(dst),
`ifdef MEM_BYTE_ACCESS_EN
        .i_byte_en(1'b0), .o_byte_en_out(z_be_o),
`endif
        .o_freeze(z_frz), .o_pc_out(z_pc_o), .o_wb_en_out(z_wb_o), .o_mem_r_en_out(z_rd_o),
        .o_alu_res_out(z_alu_o), .o_mem_data_out(z_md_o), .o_dest_out(z_dst_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Presents an access at a negedge, counts frozen cycles (bounded), checks WB
    // bubbles during the stall, and returns at the negedge after the completion edge.
    task automatic run_op(input string tag, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] v, input int exp_frz);
        int n = 0;
        rd = r; wr = w; alu = a; vrm = v;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (!frz) break;
            n++;
            @(posedge clk);
            @(negedge clk);
            check({tag, " bubble"}, 32'({wb_o, rd_o}), 32'd0);
        end
        check({tag, " stall"}, n, exp_frz);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        pc = $urandom; wb = 1'b1; rd = 1'b1; wr = 1'b1;
        alu = $urandom; vrm = $urandom; dst = 4'($urandom);
        repeat (3) @(negedge clk);
        check("rst pc", pc_o, 32'd0);
        check("rst wb", 32'(wb_o), 32'd0);
        check("rst rd", 32'(rd_o), 32'd0);
        check("rst alu", alu_o, 32'd0);
        check("rst md", md_o, 32'd0);
        check("rst dst", 32'(dst_o), 32'd0);
        check("rst frz", 32'(frz), 32'd0);

        rst_n = 1'b1;
        pc = 32'h100; wb = 1'b1; dst = 4'd3;
        run_op("nop", 1'b0, 1'b0, 32'h55, 32'h0, 0);
        check("nop wb", 32'(wb_o), 32'd1);
        check("nop alu", alu_o, 32'h55);
        check("nop dst", 32'(dst_o), 32'd3);
        check("nop pc", pc_o, 32'h100);
        check("nop rd", 32'(rd_o), 32'd0);

        pc = 32'h104; wb = 1'b0; dst = 4'd0;
        run_op("st10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2);
        check("st10 rd", 32'(rd_o), 32'd0);
        check("st10 alu", alu_o, 32'h10);
        check("st10 pc", pc_o, 32'h104);

        pc = 32'h108; wb = 1'b1; dst = 4'd5;
        run_op("ld10", 1'b1, 1'b0, 32'h10, 32'h0, 2);
        check("ld10 md", md_o, 32'hDEADBEEF);
        check("ld10 rd", 32'(rd_o), 32'd1);
        check("ld10 wb", 32'(wb_o), 32'd1);
        check("ld10 dst", 32'(dst_o), 32'd5);

        wb = 1'b0;
        run_op("st100", 1'b0, 1'b1, 32'h100, 32'h1, 2);
        wb = 1'b1;
        run_op("ld0", 1'b1, 1'b0, 32'h0, 32'h0, 2);
        check("ld0 md", md_o, 32'h1);
        run_op("ld103", 1'b1, 1'b0, 32'h103, 32'h0, 2);
        check("ld103 md", md_o, 32'h1);

        run_op("rdwr", 1'b1, 1'b1, 32'h30, 32'h77, 2);
        check("rdwr rd", 32'(rd_o), 32'd0);
        check("rdwr md", md_o, 32'd0);
        check("rdwr wb", 32'(wb_o), 32'd1);
        run_op("ld30", 1'b1, 1'b0, 32'h30, 32'h0, 2);
        check("ld30 md", md_o, 32'h77);

        wb = 1'b0;
        run_op("st8", 1'b0, 1'b1, 32'h8, 32'h1234, 2);
        rd = 1'b0; wr = 1'b1; alu = 32'h8; vrm = 32'hAAAA;
        #1 check("abort frz1", 32'(frz), 32'd1);
        @(posedge clk);
        @(negedge clk);
        #1 check("abort frz2", 32'(frz), 32'd1);
        rst_n = 1'b0;
        #1 check("abort frz0", 32'(frz), 32'd0);
        wr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wb = 1'b1;
        run_op("ld8", 1'b1, 1'b0, 32'h8, 32'h0, 2);
        check("ld8 md", md_o, 32'h1234);

`ifdef MEM_BYTE_ACCESS_EN
        be = 1'b0;
        run_op("stw20", 1'b0, 1'b1, 32'h20, 32'h11223344, 2);
        be = 1'b1;
        run_op("stb21", 1'b0, 1'b1, 32'h21, 32'h000000FF, 2);
        be = 1'b0;
        run_op("ldw20", 1'b1, 1'b0, 32'h20, 32'h0, 2);
        check("ldw20 md", md_o, 32'h1122FF44);
        be = 1'b1;
        run_op("ldb23", 1'b1, 1'b0, 32'h23, 32'h0, 2);
        check("ldb23 md", md_o, 32'h00000011);
        check("ldb23 be", 32'(be_o), 32'd1);
        be = 1'b0;
`endif
        rd = 1'b0; wr = 1'b0;

        for (int k = 1; k <= 3; k++) begin
            z_wr = 1'b1; z_rd = 1'b0; z_alu = 32'(k * 4); z_vrm = 32'(k * 32'h1111);
            #1 check("w0 st frz", 32'(z_frz), 32'd0);
            @(posedge clk);
            @(negedge clk);
            check("w0 st alu", z_alu_o, 32'(k * 4));
            check("w0 st rd", 32'(z_rd_o), 32'd0);
            z_wr = 1'b0; z_rd = 1'b1;
            #1 check("w0 ld frz", 32'(z_frz), 32'd0);
            @(posedge clk);
            @(negedge clk);
            check("w0 ld md", z_md_o, 32'(k * 32'h1111));
            check("w0 ld rd", 32'(z_rd_o), 32'd1);
        end
        z_rd = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end
endmodule
